vector_addsub_sequencer: RTL and testbench

//  Time-multiplexes one shared Adder_Substractor across all lanes of a vector ADD/SUB op.
//  - Accepts a full vector op (A, B, SUBS) through a valid/ready handshake.
//  - Feeds one lane per cycle to the external adder and collects S/Cout/V per lane.
//  - Returns the packed result vector with per-lane and aggregate flags.
//  - Sits in the Execute stage between issue and the ALU adder instance.

---
 rtl/vector_addsub_sequencer_if.sv | 49 ++++
 rtl/vector_addsub_sequencer.sv | 116 +++++++++++
 tb/tb_vector_addsub_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_addsub_sequencer_if.sv
// Bundles the operand-accept, adder and result-return signals of the vector
// add/sub sequencer. The slave view belongs to the sequencer. The master view
// belongs to its environment: the issue stage, the shared adder and the consumer.
interface vector_addsub_sequencer_if #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned LANES = 4
);
    // Operand-accept channel
    logic                     start_valid;
    logic                     start_ready;
    logic                     start_subs;
    logic [LANES*WIDTH-1:0]   start_a;
    logic [LANES*WIDTH-1:0]   start_b;

    // Shared adder, one lane per cycle
    logic [WIDTH-1:0]         au_a;
    logic [WIDTH-1:0]         au_b;
    logic                     au_subs;
    logic [WIDTH-1:0]         au_s;
    logic                     au_cout;
    logic                     au_v;

    // Result channel
    logic                     res_valid;
    logic                     res_ready;
    logic [LANES*WIDTH-1:0]   res_s;
    logic [LANES-1:0]         res_cout;
    logic [LANES-1:0]         res_v;
    logic                     res_any_v;
    logic                     busy;

    modport slave (
        input  start_valid, start_subs, start_a, start_b,
        input  au_s, au_cout, au_v,
        input  res_ready,
        output start_ready,
        output au_a, au_b, au_subs,
        output res_valid, res_s, res_cout, res_v, res_any_v, busy
    );

    modport master (
        output start_valid, start_subs, start_a, start_b,
        output au_s, au_cout, au_v,
        output res_ready,
        input  start_ready,
        input  au_a, au_b, au_subs,
        input  res_valid, res_s, res_cout, res_v, res_any_v, busy
    );
endinterface

// File: rtl/vector_addsub_sequencer.sv
// Time-multiplexes one external adder across all lanes of a vector ADD/SUB.
// The sequencer accepts the whole vector and then presents one lane per cycle
// to the adder. It captures S/Cout/V for each lane and returns the packed result.
module vector_addsub_sequencer #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    vector_addsub_sequencer_if.slave bus
);
    localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VW = LANES * WIDTH;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [VW-1:0]   a_q, a_d;
    logic [VW-1:0]   b_q, b_d;
    logic            subs_q, subs_d;
    logic [VW-1:0]   rs_q, rs_d;
    logic [LANES-1:0] rc_q, rc_d;
    logic [LANES-1:0] rv_q, rv_d;
    logic [WIDTH-1:0] au_a_c, au_b_c;
    logic             au_subs_c;

    // State, lane counter, latched operands and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            subs_q  <= 1'b0;
            rs_q    <= '0;
            rc_q    <= '0;
            rv_q    <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            a_q     <= a_d;
            b_q     <= b_d;
            subs_q  <= subs_d;
            rs_q    <= rs_d;
            rc_q    <= rc_d;
            rv_q    <= rv_d;
        end
    end

    // Next-state, per-lane capture and adder drive
    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        a_d       = a_q;
        b_d       = b_q;
        subs_d    = subs_q;
        rs_d      = rs_q;
        rc_d      = rc_q;
        rv_d      = rv_q;
        au_a_c    = '0;
        au_b_c    = '0;
        au_subs_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.start_a;
                    b_d     = bus.start_b;
                    subs_d  = bus.start_subs;
                    lane_d  = '0;
                    rs_d    = '0;
                    rc_d    = '0;
                    rv_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                au_a_c    = a_q[lane_q*WIDTH +: WIDTH];
                au_b_c    = b_q[lane_q*WIDTH +: WIDTH];
                au_subs_c = subs_q;
                rs_d[lane_q*WIDTH +: WIDTH] = bus.au_s;
                rc_d[lane_q] = bus.au_cout;
                rv_d[lane_q] = bus.au_v;
                if (lane_q == LAST_LANE) begin
                    lane_d  = '0;
                    state_d = DONE;
                end else begin
                    lane_d  = lane_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q == RUN) || (state_q == DONE);
    assign bus.au_a        = au_a_c;
    assign bus.au_b        = au_b_c;
    assign bus.au_subs     = au_subs_c;
    assign bus.res_s       = rs_q;
    assign bus.res_cout    = rc_q;
    assign bus.res_v       = rv_q;
    assign bus.res_any_v   = |rv_q;
endmodule

// File: tb/tb_vector_addsub_sequencer.sv
// Bench for vector_addsub_sequencer. It attaches a behavioural adder and
// compares every result with a plain-arithmetic reference model.
module tb_vector_addsub_sequencer;
    localparam int unsigned WIDTH = 18;
    localparam int unsigned LANES = 4;
    localparam int unsigned VW    = WIDTH * LANES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    logic [VW-1:0]    exp_s;
    logic [LANES-1:0] exp_c;
    logic [LANES-1:0] exp_v;

    vector_addsub_sequencer_if #(.WIDTH(WIDTH), .LANES(LANES)) bus();

    vector_addsub_sequencer #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Attached adder: two's-complement add/subtract, carry out, signed overflow
    logic [WIDTH:0] sum_w;
    always_comb begin
        sum_w = {1'b0, bus.au_a}
              + {1'b0, (bus.au_subs ? ~bus.au_b : bus.au_b)}
              + (WIDTH+1)'(bus.au_subs);
    end
    assign bus.au_s    = sum_w[WIDTH-1:0];
    assign bus.au_cout = sum_w[WIDTH];
    assign bus.au_v    = bus.au_subs
        ? ((bus.au_a[WIDTH-1] != bus.au_b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.au_a[WIDTH-1]))
        : ((bus.au_a[WIDTH-1] == bus.au_b[WIDTH-1]) && (sum_w[WIDTH-1] != bus.au_a[WIDTH-1]));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: integer arithmetic per lane
    task automatic model(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic subs);
        longint m, half, ua, ub, sa, sb, r, sr;
        m    = longint'(1) << WIDTH;
        half = m / 2;
        for (int k = 0; k < int'(LANES); k++) begin
            ua = longint'(a[k*WIDTH +: WIDTH]);
            ub = longint'(b[k*WIDTH +: WIDTH]);
            sa = (ua >= half) ? ua - m : ua;
            sb = (ub >= half) ? ub - m : ub;
            if (subs) begin
                r  = ua - ub;
                exp_c[k] = (ua >= ub);
                sr = sa - sb;
            end else begin
                r  = ua + ub;
                exp_c[k] = (r >= m);
                sr = sa + sb;
            end
            if (r < 0) r = r + m;
            if (r >= m) r = r - m;
            exp_s[k*WIDTH +: WIDTH] = WIDTH'(r);
            exp_v[k] = (sr >= half) || (sr < -half);
        end
    endtask

    function automatic logic [VW-1:0] pack4(input logic [WIDTH-1:0] l0, input logic [WIDTH-1:0] l1,
                                            input logic [WIDTH-1:0] l2, input logic [WIDTH-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < int'(LANES); k++) v[k*WIDTH +: WIDTH] = WIDTH'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input string tag);
        check_eq({tag, "_s"},    bus.res_s,     exp_s);
        check_eq({tag, "_cout"}, bus.res_cout,  exp_c);
        check_eq({tag, "_v"},    bus.res_v,     exp_v);
        check_eq({tag, "_anyv"}, bus.res_any_v, |exp_v);
    endtask

    // Offer an op, follow it through RUN, check latency and the result
    task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic subs, input string tag);
        int n = 0;
        model(a, b, subs);
        while (!bus.start_ready && n < 50) begin tick(); n++; end
        check_eq({tag, "_wait_ready"}, bus.start_ready, 1'b1);
        bus.start_a = a; bus.start_b = b; bus.start_subs = subs; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        check_eq({tag, "_busy"}, bus.busy, 1'b1);
        check_eq({tag, "_ready_run"}, bus.start_ready, 1'b0);
        check_eq({tag, "_au_subs"}, bus.au_subs, subs);
        for (int i = 0; i < int'(LANES); i++) begin
            if (i > 0) tick();
            check_eq({tag, "_early_valid"}, bus.res_valid, 1'b0);
            check_eq({tag, "_au_a"}, bus.au_a, a[i*WIDTH +: WIDTH]);
            check_eq({tag, "_au_b"}, bus.au_b, b[i*WIDTH +: WIDTH]);
        end
        tick();
        check_eq({tag, "_valid_lat"}, bus.res_valid, 1'b1);
        check_result(tag);
    endtask

    // Hold DONE for 'hold' cycles with ignored start pulses, then hand the result off
    task automatic retire(input int hold, input string tag);
        for (int i = 0; i < hold; i++) begin
            bus.start_valid = i[0];
            bus.start_a = rand_vec(); bus.start_b = rand_vec(); bus.start_subs = $urandom_range(0, 1);
            tick();
            check_eq({tag, "_hold_valid"}, bus.res_valid, 1'b1);
            check_eq({tag, "_hold_ready"}, bus.start_ready, 1'b0);
            check_eq({tag, "_hold_au"}, bus.au_a, '0);
            check_result({tag, "_hold"});
        end
        bus.start_valid = 1'b0;
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        check_eq({tag, "_post_valid"}, bus.res_valid, 1'b0);
        check_eq({tag, "_post_ready"}, bus.start_ready, 1'b1);
        check_eq({tag, "_post_busy"}, bus.busy, 1'b0);
        check_result({tag, "_post"});
    endtask

    initial begin
        logic [VW-1:0] a, b;
        logic subs;
        int unsigned prev_acc, acc, n, seen;

        bus.start_valid = 1'b0; bus.start_subs = 1'b0;
        bus.start_a = '0; bus.start_b = '0; bus.res_ready = 1'b0;
        #1;
        check_eq("rst_ready", bus.start_ready, 1'b1);
        check_eq("rst_valid", bus.res_valid, 1'b0);
        check_eq("rst_busy",  bus.busy, 1'b0);
        check_eq("rst_res_s", bus.res_s, '0);
        check_eq("rst_au_a",  bus.au_a, '0);
        @(negedge clk); rst = 1'b0;
        tick();

        // Directed: plain add
        issue(pack4(1, 2, 3, 4), pack4(10, 20, 30, 40), 1'b0, "add");
        check_eq("add_const", bus.res_s, pack4(11, 22, 33, 44));
        retire(0, "add");

        // Directed: subtract with borrow and overflow
        issue(pack4(5, 3, 0, 18'h20000), pack4(3, 5, 0, 1), 1'b1, "sub");
        check_eq("sub_const", bus.res_s, pack4(2, 18'h3FFFE, 0, 18'h1FFFF));
        check_eq("sub_cout_const", bus.res_cout, 4'b1101);
        check_eq("sub_v_const", bus.res_v, 4'b1000);
        retire(1, "sub");

        // Directed: add overflow and carry
        issue(pack4(18'h1FFFF, 18'h3FFFF, 0, 5), pack4(1, 1, 0, 6), 1'b0, "addov");
        check_eq("addov_cout_const", bus.res_cout, 4'b0010);
        check_eq("addov_v_const", bus.res_v, 4'b0001);
        retire(0, "addov");

        // Backpressure with ignored start pulses
        issue(rand_vec(), rand_vec(), 1'b1, "bp");
        retire(10, "bp");

        // Reset while in RUN at lane 2
        model(pack4(7, 8, 9, 10), pack4(1, 1, 1, 1), 1'b0);
        bus.start_a = pack4(7, 8, 9, 10); bus.start_b = pack4(1, 1, 1, 1);
        bus.start_subs = 1'b0; bus.start_valid = 1'b1;
        tick();
        bus.start_valid = 1'b0;
        tick(); tick();
        check_eq("mid_au_a_lane2", bus.au_a, 18'd9);
        #2 rst = 1'b1;
        #1;
        check_eq("mid_rst_ready", bus.start_ready, 1'b1);
        check_eq("mid_rst_valid", bus.res_valid, 1'b0);
        check_eq("mid_rst_busy",  bus.busy, 1'b0);
        check_eq("mid_rst_res_s", bus.res_s, '0);
        check_eq("mid_rst_au_a",  bus.au_a, '0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); seen = seen | 32'(bus.res_valid); end
        check_eq("mid_rst_no_result", seen, 0);
        issue(rand_vec(), rand_vec(), 1'b0, "after_rst");
        retire(0, "after_rst");

        // Randomized ops
        for (int k = 0; k < 20; k++) begin
            issue(rand_vec(), rand_vec(), 1'($urandom_range(0, 1)), "rnd");
            retire(int'($urandom_range(0, 2)), "rnd");
        end

        // Back-to-back with start_valid and res_ready held high
        bus.res_ready = 1'b1;
        bus.start_valid = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 6; k++) begin
            a = rand_vec(); b = rand_vec(); subs = 1'($urandom_range(0, 1));
            bus.start_a = a; bus.start_b = b; bus.start_subs = subs;
            model(a, b, subs);
            n = 0;
            while (!bus.start_ready && n < 50) begin tick(); n++; end
            check_eq("b2b_wait_ready", bus.start_ready, 1'b1);
            tick();
            acc = cyc;
            if (k > 0) check_eq("b2b_period", acc - prev_acc, LANES + 2);
            prev_acc = acc;
            n = 0;
            while (!bus.res_valid && n < 50) begin tick(); n++; end
            check_eq("b2b_latency", n, LANES);
            check_result("b2b");
        end
        bus.start_valid = 1'b0;
        tick();
        bus.res_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
